// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and sizing helpers for the PLL reset sequencer
package pll_seq_pkg;

    typedef enum logic [1:0] {
        S_PLLRST    = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'(1) << r) < 64'(v))
            r++;
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level, resets to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            {q, meta} <= 2'b00;
        else
            {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses PLL reset, waits for stable lock, then releases system reset
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] retry_count
);

    localparam int CLG = clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam int CW  = (CLG < 1) ? 1 : CLG;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          locked_s;
    logic          retry_inc, loss_inc;

    sync_2ff u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (pll_locked),
        .q    (locked_s)
    );

    always_comb begin
        state_n   = state;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state)
            S_PLLRST:
                state_n = (cnt == CW'(PLL_RST_CYCLES - 1)) ? S_WAIT_LOCK : S_PLLRST;
            S_WAIT_LOCK: begin
                retry_inc = !locked_s && (cnt == CW'(LOCK_TIMEOUT - 1));
                state_n   = locked_s ? S_STABLE : (retry_inc ? S_PLLRST : S_WAIT_LOCK);
            end
            S_STABLE:
                state_n = !locked_s ? S_WAIT_LOCK
                        : (cnt == CW'(STABLE_CYCLES - 1)) ? S_RUN : S_STABLE;
            S_RUN: begin
                loss_inc = !locked_s;
                state_n  = loss_inc ? S_WAIT_LOCK : S_RUN;
            end
            default:
                state_n = S_PLLRST;
        endcase
    end

    // Outputs decode state_n so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_PLLRST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_rst_n   <= 1'b0;
            ready       <= 1'b0;
            loss_count  <= '0;
            retry_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= (state_n != state) ? '0 : cnt + 1'b1;
            pll_rst     <= (state_n == S_PLLRST);
            sys_rst_n   <= (state_n == S_RUN);
            ready       <= (state_n == S_RUN);
            if (retry_inc && retry_count != '1)
                retry_count <= retry_count + 1'b1;
            if (loss_inc && loss_count != '1)
                loss_count <= loss_count + 1'b1;
        end
    end

endmodule
